// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: issues a one-cycle tick every (div+1) cycles while running,
// with a divided-clock level, a tick counter and optional burst termination.
module clk_en_sched #(
    parameter int unsigned DIV_W = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_burst,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             clk_div,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tick_cnt
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] burst_q;
    logic [DIV_W-1:0] cnt_q;
    logic [CNT_W-1:0] tick_cnt_q;
    logic             tick_q;
    logic             clk_div_q;
    logic             done_q;

    logic             cfg_take;
    logic             launch;
    logic             advance;
    logic [DIV_W-1:0] eff_div;
    logic [CNT_W-1:0] eff_burst;
    logic [DIV_W-1:0] phase;
    logic             period_end;
    logic [CNT_W-1:0] tick_base;
    logic [CNT_W-1:0] tick_next;
    logic             burst_end;
    logic             abort;

    // Decode the current cycle: which config applies and whether it closes a period.
    // The start cycle itself counts as phase 0, so the first tick lands div+1 cycles later.
    always_comb begin
        cfg_take   = cfg_valid && (state_q == StIdle);
        launch     = start && (state_q == StIdle);
        advance    = (state_q == StRun) && !stop;
        abort      = (state_q == StRun) && stop;
        eff_div    = cfg_take ? cfg_div : div_q;
        eff_burst  = cfg_take ? cfg_burst : burst_q;
        phase      = launch ? '0 : cnt_q;
        period_end = (launch || advance) && (phase == eff_div);
        tick_base  = launch ? '0 : tick_cnt_q;
        tick_next  = tick_base + CNT_W'(1);
        burst_end  = period_end && (eff_burst != '0) && (tick_next == eff_burst);
    end

    // FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            div_q      <= '0;
            burst_q    <= '0;
            cnt_q      <= '0;
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            clk_div_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tick_q <= period_end;
            done_q <= burst_end;

            if (cfg_take) begin
                div_q   <= cfg_div;
                burst_q <= cfg_burst;
            end

            if (period_end) begin
                tick_cnt_q <= tick_next;
            end else if (launch) begin
                tick_cnt_q <= '0;
            end

            if (burst_end || abort) begin
                state_q   <= StIdle;
                clk_div_q <= 1'b0;
                cnt_q     <= '0;
            end else if (launch || advance) begin
                state_q <= StRun;
                cnt_q   <= period_end ? '0 : phase + DIV_W'(1);
                // A fresh run starts the divided clock from low.
                if (launch) begin
                    clk_div_q <= period_end;
                end else if (period_end) begin
                    clk_div_q <= ~clk_div_q;
                end
            end
        end
    end

    assign cfg_ready = (state_q == StIdle);
    assign busy      = (state_q == StRun);
    assign tick      = tick_q;
    assign clk_div   = clk_div_q;
    assign done      = done_q;
    assign tick_cnt  = tick_cnt_q;

endmodule

// File: tb/tb_clk_en_sched.sv
// Directed bench for clk_en_sched; cycle c means c clock edges after the start-sampling edge.
module tb_clk_en_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_div;
    logic [3:0] cfg_burst;
    logic       start;
    logic       stop;
    logic       tick;
    logic       clk_div;
    logic       busy;
    logic       done;
    logic [3:0] tick_cnt;

    int checks = 0;
    int errors = 0;

    clk_en_sched #(
        .DIV_W(4),
        .CNT_W(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_div  (cfg_div),
        .cfg_burst(cfg_burst),
        .start    (start),
        .stop     (stop),
        .tick     (tick),
        .clk_div  (clk_div),
        .busy     (busy),
        .done     (done),
        .tick_cnt (tick_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // clk_div is expected to equal the parity of ticks while running, and low when idle.
    task automatic expect_outs(input string tag, input logic e_tick, input logic e_busy,
                               input logic e_done, input logic [3:0] e_cnt);
        chk({tag, ".tick"}, 32'(tick), 32'(e_tick));
        chk({tag, ".clk_div"}, 32'(clk_div), 32'(e_busy & e_cnt[0]));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(!e_busy));
        chk({tag, ".done"}, 32'(done), 32'(e_done));
        chk({tag, ".tick_cnt"}, 32'(tick_cnt), 32'(e_cnt));
    endtask

    task automatic cfg(input logic [3:0] d, input logic [3:0] b);
        cfg_valid = 1'b1;
        cfg_div   = d;
        cfg_burst = b;
        step();
        cfg_valid = 1'b0;
    endtask

    // Free-running div=0 run with stop asserted during cycle n.
    task automatic run_free(input string tag, input int n);
        cfg(4'd0, 4'd0);
        start = 1'b1;
        for (int c = 1; c <= n; c++) begin
            step();
            start = 1'b0;
            expect_outs($sformatf("%s c%0d", tag, c), 1'b1, 1'b1, 1'b0, 4'(c));
            stop = (c == n);
        end
        step();
        stop = 1'b0;
        expect_outs($sformatf("%s after stop", tag), 1'b0, 1'b0, 1'b0, 4'(n));
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        cfg_burst = '0;
        start     = 1'b0;
        stop      = 1'b0;
        step();
        step();
        rst = 1'b0;
        expect_outs("reset", 1'b0, 1'b0, 1'b0, 4'd0);

        // Burst run div=3 burst=4: ticks at 4, 8, 12, 16; done at 16.
        cfg(4'd3, 4'd4);
        start = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            step();
            start = 1'b0;
            expect_outs($sformatf("burst c%0d", c), (c % 4 == 0) && (c <= 16), c < 16,
                        c == 16, 4'(c / 4));
        end

        // Free-running, stop after 10 cycles; then a longer run to show the count wrapping.
        run_free("free10", 10);
        run_free("free18", 18);

        // Config and start sampled together: new div=1 burst=2 overrides old div=5.
        cfg(4'd5, 4'd0);
        cfg_valid = 1'b1;
        cfg_div   = 4'd1;
        cfg_burst = 4'd2;
        start     = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            start     = 1'b0;
            cfg_valid = 1'b0;
            expect_outs($sformatf("cfgstart c%0d", c), (c == 2) || (c == 4), c < 4, c == 4,
                        4'(c >= 4 ? 2 : (c >= 2 ? 1 : 0)));
        end

        // div=2 burst=5, start re-asserted in RUN (ignored), stop coincident with 3rd tick.
        cfg(4'd2, 4'd5);
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            expect_outs($sformatf("stopwin c%0d", c), (c == 3) || (c == 6), c < 9, 1'b0,
                        4'(c >= 6 ? 2 : (c >= 3 ? 1 : 0)));
            start = (c == 4);
            stop  = (c == 8);
        end

        // Config offered during RUN is ignored; period stays div=2 for this and next run.
        start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            expect_outs($sformatf("cfgrun c%0d", c), (c == 3) || (c == 6), c < 8, 1'b0,
                        4'(c >= 6 ? 2 : (c >= 3 ? 1 : 0)));
            start     = 1'b0;
            cfg_valid = (c == 1);
            cfg_div   = 4'd7;
            cfg_burst = 4'd1;
            stop      = (c == 7);
        end
        cfg_valid = 1'b0;
        start     = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            start = 1'b0;
            expect_outs($sformatf("nextrun c%0d", c), c == 3, c < 4, 1'b0, 4'(c >= 3 ? 1 : 0));
            stop = (c == 3);
        end

        // Reset mid-run at cycle 6 of div=1 free run.
        cfg(4'd1, 4'd0);
        start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            start = 1'b0;
            expect_outs($sformatf("midrst c%0d", c), (c < 7) && (c % 2 == 0), c < 7, 1'b0,
                        4'(c < 7 ? c / 2 : 0));
            rst = (c == 6);
        end
        rst = 1'b0;

        // Restart after reset uses div=0; start and stop together in IDLE: start wins.
        start = 1'b1;
        stop  = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            start = 1'b0;
            expect_outs($sformatf("postrst c%0d", c), c < 3, c < 3, 1'b0, 4'(c < 3 ? c : 2));
            stop = (c == 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
